// File: rtl/cpu_pkg.sv
// Shared CPU definitions: opcode constants, NOP word, fetch FSM states and
// the default reset PC used by the instruction-fetch stage.
package cpu_pkg;

    localparam logic [5:0]  OP_RTYPE = 6'b000000;
    localparam logic [5:0]  OP_ADDI  = 6'b001000;
    localparam logic [5:0]  OP_BEQ   = 6'b000100;
    localparam logic [5:0]  OP_SLTI  = 6'b001010;

    localparam logic [31:0] NOP_WORD         = 32'h0000_0000;
    localparam logic [31:0] DEFAULT_RESET_PC = 32'h0000_0000;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FETCH = 2'd1,
        ST_HOLD  = 2'd2,
        ST_FLUSH = 2'd3
    } fetch_state_t;

    function automatic logic [5:0] get_opcode(input logic [31:0] instr);
        return instr[31:26];
    endfunction

endpackage

// File: rtl/fetch_skid_buf.sv
// One-entry {instr, pc_plus4} holding register that catches a fetch which
// returns while the decode-facing slot is occupied and stalled.
module fetch_skid_buf
    import cpu_pkg::*;
#(
    parameter int ADDR_W = 32
) (
    input  logic              clk_i,
    input  logic              rst_i,
    input  logic              i_load,
    input  logic              i_unload,
    input  logic              i_clear,
    input  logic [31:0]       i_instr,
    input  logic [ADDR_W-1:0] i_pc_plus4,
    output logic              o_valid,
    output logic [31:0]       o_instr,
    output logic [ADDR_W-1:0] o_pc_plus4
);

    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;

    // Clear and unload both empty the entry; neither coincides with a load.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_valid    <= 1'b0;
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= '0;
        end else if (i_clear || i_unload) begin
            r_valid    <= 1'b0;
        end else if (i_load) begin
            r_valid    <= 1'b1;
            r_instr    <= i_instr;
            r_pc_plus4 <= i_pc_plus4;
        end
    end

    assign o_valid    = r_valid;
    assign o_instr    = r_instr;
    assign o_pc_plus4 = r_pc_plus4;

endmodule

// File: rtl/instr_fetch_stage.sv
// MIPS instruction-fetch stage: owns the PC, fetches words over a req/ack
// handshake and hands a registered instruction plus PC+4 to decode.
module instr_fetch_stage
    import cpu_pkg::*;
#(
    parameter int                ADDR_W   = 32,
    parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(DEFAULT_RESET_PC)
) (
    input  logic              clk_i,
    input  logic              rst_i,
    output logic              imem_req_o,
    output logic [ADDR_W-1:0] imem_addr_o,
    input  logic              imem_ack_i,
    input  logic [31:0]       imem_data_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    input  logic              stall_i,
    output logic              instr_valid_o,
    output logic [31:0]       instr_o,
    output logic [5:0]        opcode_o,
    output logic [ADDR_W-1:0] pc_plus4_o
);

    fetch_state_t      r_state;
    logic [ADDR_W-1:0] r_pc;
    logic [ADDR_W-1:0] r_addr;
    logic              r_req;
    logic              r_valid;
    logic [31:0]       r_instr;
    logic [ADDR_W-1:0] r_pc_plus4;

    logic              w_consume;
    logic              w_slot_free;
    logic [ADDR_W-1:0] w_pc_plus4;
    logic [ADDR_W-1:0] w_redir_pc;
    logic              w_redirect;
    logic              w_skid_load;
    logic              w_skid_unload;
    logic              w_skid_valid;
    logic [31:0]       w_skid_instr;
    logic [ADDR_W-1:0] w_skid_pc_plus4;

    assign w_consume   = r_valid & ~stall_i;
    assign w_slot_free = ~r_valid | w_consume;
    assign w_pc_plus4  = r_pc + ADDR_W'(4);
    assign w_redir_pc  = {redirect_pc_i[ADDR_W-1:2], 2'b00};
    assign w_redirect  = redirect_i & (r_state != ST_IDLE);

    assign w_skid_load   = (r_state == ST_FETCH) & ~redirect_i & imem_ack_i & ~w_slot_free;
    assign w_skid_unload = (r_state == ST_HOLD) & ~redirect_i & w_consume;

    fetch_skid_buf #(
        .ADDR_W (ADDR_W)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .i_load     (w_skid_load),
        .i_unload   (w_skid_unload),
        .i_clear    (w_redirect),
        .i_instr    (imem_data_i),
        .i_pc_plus4 (w_pc_plus4),
        .o_valid    (w_skid_valid),
        .o_instr    (w_skid_instr),
        .o_pc_plus4 (w_skid_pc_plus4)
    );

    // r_addr is the address presented to memory; it only moves when no
    // request is pending, so FLUSH keeps the pre-redirect address.
    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            r_state    <= ST_IDLE;
            r_pc       <= RESET_PC;
            r_addr     <= RESET_PC;
            r_req      <= 1'b0;
            r_valid    <= 1'b0;
            r_instr    <= NOP_WORD;
            r_pc_plus4 <= '0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_state <= ST_FETCH;
                    r_req   <= 1'b1;
                    r_addr  <= r_pc;
                end

                ST_FETCH: begin
                    if (redirect_i) begin
                        r_pc    <= w_redir_pc;
                        r_valid <= 1'b0;
                        if (imem_ack_i) begin
                            r_addr <= w_redir_pc;
                        end else begin
                            r_state <= ST_FLUSH;
                        end
                    end else if (imem_ack_i) begin
                        r_pc <= w_pc_plus4;
                        if (w_slot_free) begin
                            r_instr    <= imem_data_i;
                            r_pc_plus4 <= w_pc_plus4;
                            r_valid    <= 1'b1;
                            r_addr     <= w_pc_plus4;
                        end else begin
                            r_state <= ST_HOLD;
                            r_req   <= 1'b0;
                        end
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                end

                ST_HOLD: begin
                    if (redirect_i) begin
                        r_pc    <= w_redir_pc;
                        r_addr  <= w_redir_pc;
                        r_valid <= 1'b0;
                        r_state <= ST_FETCH;
                        r_req   <= 1'b1;
                    end else if (w_consume) begin
                        r_instr    <= w_skid_instr;
                        r_pc_plus4 <= w_skid_pc_plus4;
                        r_valid    <= w_skid_valid;
                        r_addr     <= r_pc;
                        r_state    <= ST_FETCH;
                        r_req      <= 1'b1;
                    end
                end

                ST_FLUSH: begin
                    // Stale data is dropped; a redirect landing on the ack
                    // cycle still becomes the next fetch address.
                    if (redirect_i) begin
                        r_pc    <= w_redir_pc;
                        r_valid <= 1'b0;
                    end else if (w_consume) begin
                        r_valid <= 1'b0;
                    end
                    if (imem_ack_i) begin
                        r_state <= ST_FETCH;
                        r_addr  <= redirect_i ? w_redir_pc : r_pc;
                    end
                end

                default: begin
                    r_state <= ST_IDLE;
                    r_req   <= 1'b0;
                    r_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req_o    = r_req;
    assign imem_addr_o   = r_addr;
    assign instr_valid_o = r_valid;
    assign instr_o       = r_instr;
    assign opcode_o      = get_opcode(r_instr);
    assign pc_plus4_o    = r_pc_plus4;

endmodule

// File: tb/tb_instr_fetch_stage.sv
// Directed bench for instr_fetch_stage: a latency-programmable memory model
// plus a scoreboard of instructions decode is expected to consume, in order.
module tb_instr_fetch_stage;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ack;
    logic [31:0] imem_data;
    logic        redirect;
    logic [31:0] redirect_pc;
    logic        stall;
    logic        instr_valid;
    logic [31:0] instr;
    logic [5:0]  opcode;
    logic [31:0] pc_plus4;

    int          n_checks = 0;
    int          n_pass   = 0;
    logic [63:0] sb_q[$];
    int          mem_lat  = 0;
    logic        mem_en   = 1'b1;
    int          mem_cnt  = 0;

    instr_fetch_stage #(
        .ADDR_W   (32),
        .RESET_PC (32'h0000_0000)
    ) dut (
        .clk_i         (clk),
        .rst_i         (rst_n),
        .imem_req_o    (imem_req),
        .imem_addr_o   (imem_addr),
        .imem_ack_i    (imem_ack),
        .imem_data_i   (imem_data),
        .redirect_i    (redirect),
        .redirect_pc_i (redirect_pc),
        .stall_i       (stall),
        .instr_valid_o (instr_valid),
        .instr_o       (instr),
        .opcode_o      (opcode),
        .pc_plus4_o    (pc_plus4)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'h0)
            return 32'h2008_0005;
        else if (a == 32'h4)
            return 32'h1000_0003;
        else
            return a ^ 32'h8C00_0000;
    endfunction

    // Memory acks after mem_lat extra cycles of a held request.
    always_comb begin
        imem_ack  = imem_req && mem_en && (mem_cnt >= mem_lat);
        imem_data = mem_word(imem_addr);
    end

    always @(posedge clk) begin
        if (!imem_req || imem_ack)
            mem_cnt <= 0;
        else
            mem_cnt <= mem_cnt + 1;
    end

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks = n_checks + 1;
        assert (obs === exp) n_pass = n_pass + 1;
        else $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    endtask

    task automatic exp_push(input logic [31:0] a);
        sb_q.push_back({mem_word(a), a + 32'd4});
    endtask

    // One clock: score a consume before the edge, then check that a request
    // left pending by the edge is still presented with the same address.
    task automatic cyc();
        logic        pend;
        logic [31:0] paddr;
        logic [63:0] e;
        #1;
        pend  = imem_req & ~imem_ack;
        paddr = imem_addr;
        if (instr_valid && !stall) begin
            chk("sb_has_entry", 64'(sb_q.size() != 0), 64'd1);
            if (sb_q.size() != 0) begin
                e = sb_q.pop_front();
                chk("sb_instr", {instr, pc_plus4}, e);
            end
        end
        @(posedge clk);
        #1;
        if (pend && rst_n)
            chk("req_hold", 64'({imem_req, imem_addr}), 64'({1'b1, paddr}));
    endtask

    initial begin
        rst_n       = 1'b0;
        redirect    = 1'b0;
        redirect_pc = 32'h0;
        stall       = 1'b0;
        #2;
        chk("rst_req_valid", 64'({imem_req, instr_valid}), 64'd0);
        chk("rst_instr", 64'(instr), 64'd0);
        chk("rst_pc4", 64'(pc_plus4), 64'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        chk("idle_no_req", 64'(imem_req), 64'd0);

        // Zero-wait memory, no stall: one instruction per cycle.
        exp_push(32'h00); exp_push(32'h04); exp_push(32'h08); exp_push(32'h0C);
        exp_push(32'h10); exp_push(32'h14); exp_push(32'h18);
        cyc();
        chk("p1_first_req", 64'({imem_req, imem_addr, instr_valid}), 64'({1'b1, 32'h0, 1'b0}));
        cyc();
        chk("p1_valid0", 64'(instr_valid), 64'd1);
        chk("p1_opcode0", 64'(opcode), 64'(6'b001000));
        chk("p1_pc4_0", 64'(pc_plus4), 64'h4);
        chk("p1_addr1", 64'(imem_addr), 64'h4);
        cyc();
        chk("p1_opcode1", 64'(opcode), 64'(6'b000100));
        chk("p1_pc4_1", 64'(pc_plus4), 64'h8);
        chk("p1_addr2", 64'(imem_addr), 64'h8);
        cyc();

        // Two-cycle memory: valid pulses every other cycle.
        mem_lat = 1;
        cyc();
        chk("p2_gap0", 64'({instr_valid, imem_addr}), 64'({1'b0, 32'h0C}));
        cyc();
        chk("p2_pulse0", 64'({instr_valid, imem_addr, pc_plus4}), 64'({1'b1, 32'h10, 32'h10}));
        cyc();
        chk("p2_gap1", 64'({instr_valid, imem_addr}), 64'({1'b0, 32'h10}));
        cyc();
        chk("p2_pulse1", 64'({instr_valid, pc_plus4}), 64'({1'b1, 32'h14}));

        // Stall for three cycles while an ack lands -> HOLD via the skid.
        stall = 1'b1;
        cyc();
        chk("p3_wait", 64'({instr_valid, imem_req, imem_addr}), 64'({2'b11, 32'h14}));
        cyc();
        chk("p3_hold_req", 64'(imem_req), 64'd0);
        chk("p3_hold_slot", 64'(pc_plus4), 64'h14);
        cyc();
        chk("p3_hold_still", 64'({imem_req, instr_valid}), 64'({1'b0, 1'b1}));
        stall   = 1'b0;
        mem_lat = 0;
        cyc();
        chk("p3_skid_out", {instr, pc_plus4}, {mem_word(32'h14), 32'h18});
        chk("p3_resume", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h18}));
        cyc();

        // Redirect while a request is pending without ack -> FLUSH.
        mem_en      = 1'b0;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0043;
        exp_push(32'h40);
        cyc();
        redirect = 1'b0;
        chk("p4_flush", 64'({instr_valid, imem_req, imem_addr}), 64'({2'b01, 32'h1C}));
        cyc();
        chk("p4_flush_addr", 64'(imem_addr), 64'h1C);
        mem_en = 1'b1;
        cyc();
        chk("p4_after_flush", 64'({instr_valid, imem_req, imem_addr}), 64'({2'b01, 32'h40}));
        cyc();
        chk("p4_target", 64'({instr_valid, pc_plus4}), 64'({1'b1, 32'h44}));

        // Redirect coincident with an ack: data dropped.
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0100;
        exp_push(32'h100);
        cyc();
        redirect = 1'b0;
        chk("p5_drop", 64'({instr_valid, imem_addr}), 64'({1'b0, 32'h100}));
        cyc();
        chk("p5_target", 64'({instr_valid, pc_plus4}), 64'({1'b1, 32'h104}));

        // PC wrap at the top of the address space.
        redirect    = 1'b1;
        redirect_pc = 32'hFFFF_FFFF;
        exp_push(32'hFFFF_FFFC);
        cyc();
        redirect = 1'b0;
        chk("p6_addr_top", 64'({instr_valid, imem_addr}), 64'({1'b0, 32'hFFFF_FFFC}));
        cyc();
        chk("p6_wrap", 64'({instr_valid, pc_plus4, imem_addr}), 64'({1'b1, 32'h0, 32'h0}));
        mem_en = 1'b0;
        cyc();
        chk("p6_pending", 64'({imem_req, instr_valid, imem_addr}), 64'({2'b10, 32'h0}));
        chk("p6_instr_held", 64'(instr), 64'(mem_word(32'hFFFF_FFFC)));

        // Asynchronous reset in the middle of a request.
        #2;
        rst_n = 1'b0;
        #1;
        chk("p6_rst_ctl", 64'({imem_req, instr_valid, imem_addr}), 64'd0);
        chk("p6_rst_instr", 64'({instr, pc_plus4}), 64'd0);

        // Restart; a redirect during IDLE must be ignored.
        mem_en = 1'b1;
        @(negedge clk);
        rst_n       = 1'b1;
        redirect    = 1'b1;
        redirect_pc = 32'h0000_0200;
        exp_push(32'h0);
        cyc();
        redirect = 1'b0;
        chk("p7_first_addr", 64'({imem_req, imem_addr}), 64'({1'b1, 32'h0}));
        cyc();
        chk("p7_first_instr", 64'({instr_valid, opcode, pc_plus4}), 64'({1'b1, 6'b001000, 32'h4}));
        cyc();
        chk("sb_drained", 64'(sb_q.size()), 64'd0);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule

// File: doc/instr_fetch_stage.md
Name: instr_fetch_stage

Overview:
- Instruction-fetch stage of the MIPS CPU; sits directly upstream of the main control decoder.
- Owns the PC and issues word fetches to instruction memory over a req/ack handshake.
- Presents a registered instruction, its PC+4 and a valid flag to the decode stage.
- Accepts taken-branch redirects from downstream; downstream back-pressure arrives as stall_i.

Parameters:
- RESET_PC, 32'h0000_0000, PC value loaded on reset.
- ADDR_W, 32, PC/address width (bits [1:0] always 00).

Ports:
- clk_i  input  1  clock, all state on rising edge.
- rst_i  input  1  asynchronous, active-low reset.
- imem_req_o  output  1  fetch request; held until imem_ack_i.
- imem_addr_o  output  ADDR_W  fetch address; stable while imem_req_o=1.
- imem_ack_i  input  1  memory returns imem_data_i this cycle; may be same cycle as req.
- imem_data_i  input  32  fetched instruction word.
- redirect_i  input  1  taken branch; load redirect_pc_i and flush.
- redirect_pc_i  input  ADDR_W  branch target; bits [1:0] ignored and forced to 00.
- stall_i  input  1  decode stage cannot accept an instruction this cycle.
- instr_valid_o  output  1  instr_o/pc_plus4_o hold a live instruction.
- instr_o  output  32  registered instruction word.
- opcode_o  output  6  instr_o[31:26]; drives decoder instr_op_i.
- pc_plus4_o  output  ADDR_W  address of instr_o plus 4.

Behaviour:
- Reset (rst_i=0, asynchronous):
  - pc=RESET_PC; state=IDLE.
  - imem_req_o=0, instr_valid_o=0, instr_o=0, pc_plus4_o=0, skid empty.
- Consume: consume = instr_valid_o & ~stall_i. The output slot is free when instr_valid_o=0 or consume=1.
- FSM states: IDLE, FETCH, HOLD, FLUSH.
- IDLE:
  - imem_req_o=0.
  - Goes to FETCH next cycle; this is the only reset-exit cycle.
- FETCH:
  - imem_req_o=1, imem_addr_o=pc.
  - On ack with the slot free: slot <= {imem_data_i, pc+4}, instr_valid_o<=1, pc<=pc+4, stay in FETCH.
  - On ack with the slot occupied and stalled: skid <= {data, pc+4}, pc<=pc+4, go to HOLD.
  - With no ack, hold state; addr stays stable.
  - When the slot is consumed with no ack, instr_valid_o<=0.
- HOLD:
  - imem_req_o=0.
  - On consume: slot <= skid, skid empty, go to FETCH.
- FLUSH (a request was outstanding when redirected):
  - imem_req_o=1 with the old address (protocol requires req/addr stable until ack).
  - On ack the data is discarded and the FSM goes to FETCH; pc already holds the target.
- Redirect has the highest priority, in any non-IDLE state:
  - pc<=redirect_pc_i&~3; instr_valid_o<=0; skid cleared.
  - FETCH with req=1 and no ack the same cycle goes to FLUSH.
  - FETCH with ack the same cycle discards the data and stays in FETCH.
  - HOLD goes to FETCH.
  - FLUSH stays in FLUSH with the new pc.
- Redirect and consume in the same cycle: the consume completes; the slot is then cleared.
- Redirect is ignored in IDLE. The first fetch is always RESET_PC.
- Throughput: with zero-wait memory (ack same cycle as req) and stall_i=0, one instruction per cycle. First instr_valid_o is at the 2nd rising edge after reset release.
- Latency: imem ack to instr_valid_o is 1 cycle.
- PC wrap: 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag. pc_plus4_o wraps identically.
- Reset mid-transaction: all state is cleared immediately and any in-flight ack is ignored. Memory must tolerate req dropping.
- instr_o holds its last value while instr_valid_o=0, except after reset (0).

Decomposition:
- Shared package cpu_pkg:
  - opcode constants OP_RTYPE=6'b000000, OP_ADDI=6'b001000, OP_BEQ=6'b000100, OP_SLTI=6'b001010.
  - NOP word 32'h0000_0000.
  - fetch FSM state enum.
  - default RESET_PC.
- One sub-module: fetch_skid_buf, a 1-entry {instr, pc_plus4} holding register with load/unload/clear.

Test Plan:
- Reset release, zero-wait memory returning 32'h2008_0005 at 0x0 and 32'h1000_0003 at 0x4, stall_i=0 -> imem_addr_o 0x0,0x4,0x8 on consecutive cycles; opcode_o 6'b001000 then 6'b000100; pc_plus4_o 0x4 then 0x8.
- 2-cycle memory latency -> imem_addr_o stable while req=1; instr_valid_o pulses once per 2 cycles; no address skipped.
- stall_i high for 3 cycles while an ack arrives -> FSM enters HOLD and req drops; after stall_i falls, skid instruction appears next cycle and fetch resumes at the following address, with no loss or duplication.
- redirect_i=1, redirect_pc_i=0x0000_0043 while req outstanding without ack -> FLUSH; stale ack data is never valid; next request address is 0x40.
- redirect_i coincident with ack -> data dropped, instr_valid_o=0 next cycle, next imem_addr_o = target.
- Redirect to 0xFFFF_FFFC, stall_i=0 -> pc_plus4_o=0x0 and next imem_addr_o=0x0; then assert rst_i=0 mid-request -> all outputs return to reset values immediately.
